// File: rtl/inst_prefetch.sv
// Instruction prefetch unit: a single-outstanding memory fetcher feeding a small
// {pc, inst} queue that drives a registered decode interface with jump/stall/flush control.
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic                     i_jump,
    input  logic [31:0]              i_jump_addr,
    input  logic [31:0]              i_inst_data,
    input  logic                     i_inst_ack,
    output logic                     o_inst_req,
    output logic [31:0]              o_inst_req_addr,
    output logic [31:0]              o_inst_data,
    output logic [31:0]              o_pc,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               drop_q, drop_d;
    logic [31:0]        fpc_q, fpc_d;
    logic               req_q, req_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        pc_q, pc_d;
    logic               valid_q, valid_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]        fifo_pc_q   [DEPTH];
    logic [31:0]        fifo_inst_q [DEPTH];

    logic               ack_v;
    logic               push;
    logic               pop;
    logic               issue;
    logic [LVL_W-1:0]   level_after;

    // Fetch FSM, queue bookkeeping and decode-side output selection.
    always_comb begin
        ack_v       = i_inst_ack & req_q;
        push        = ack_v & ~drop_q & ~i_jump;
        pop         = ~i_jump & ~i_stall & ~i_flush & (level_q != '0);
        level_after = level_q + LVL_W'(push) - LVL_W'(pop);
        issue       = 1'b0;
        state_d     = state_q;
        drop_d      = drop_q;
        fpc_d       = fpc_q;
        req_d       = req_q;
        req_addr_d  = req_addr_q;

        if (i_jump) begin
            fpc_d = i_jump_addr;
            // A live request must still complete on the bus, so its data is drained.
            if (req_q && !i_inst_ack) begin
                state_d = S_DRAIN;
                drop_d  = 1'b1;
            end else begin
                state_d = S_IDLE;
                drop_d  = 1'b0;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    issue = (level_after < LVL_W'(DEPTH));
                end
                S_REQ: begin
                    if (ack_v) begin
                        fpc_d   = fpc_q + 32'd4;
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                        issue   = (level_after < LVL_W'(DEPTH));
                    end
                end
                S_DRAIN: begin
                    if (ack_v) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    req_d   = 1'b0;
                end
            endcase
        end

        if (issue) begin
            state_d    = S_REQ;
            req_d      = 1'b1;
            req_addr_d = fpc_d;
        end

        if (i_jump) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            level_d  = level_after;
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end

        data_d  = data_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (i_jump) begin
            data_d  = NOP_INST;
            valid_d = 1'b0;
            pc_d    = i_jump_addr;
        end else if (i_stall) begin
            data_d  = data_q;
        end else if (pop) begin
            data_d  = fifo_inst_q[rd_ptr_q];
            pc_d    = fifo_pc_q[rd_ptr_q];
            valid_d = 1'b1;
        end else begin
            data_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            drop_q     <= 1'b0;
            fpc_q      <= RESET_PC;
            req_q      <= 1'b0;
            req_addr_q <= 32'h0;
            data_q     <= NOP_INST;
            pc_q       <= 32'h0;
            valid_q    <= 1'b0;
            level_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            drop_q     <= drop_d;
            fpc_q      <= fpc_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Queue storage needs no reset; occupancy alone says which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= req_addr_q;
            fifo_inst_q[wr_ptr_q] <= i_inst_data;
        end
    end

    assign o_inst_req      = req_q;
    assign o_inst_req_addr = req_addr_q;
    assign o_inst_data     = data_q;
    assign o_pc            = pc_q;
    assign o_valid         = valid_q;
    assign o_level         = level_q;

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 The block SHALL expose the following parameters:
  DEPTH, 4, instruction queue entries (power of two, 2..16)
  RESET_PC, 32'h0000_0000, first fetch address after reset
  NOP_INST, 32'h0000_0013, instruction emitted for bubbles, flushes and jumps
REQ-002 The block SHALL expose the following ports:
  i_clk  input  1  CPU clock, rising-edge active
  i_rst_n  input  1  reset, asynchronous, active-low
  i_stall  input  1  decode not ready; hold outputs
  i_flush  input  1  inject NOP_INST into decode this cycle
  i_jump  input  1  redirect fetch to i_jump_addr
  i_jump_addr  input  32  redirect target (word-aligned)
  i_inst_data  input  32  memory read data, valid with i_inst_ack
  i_inst_ack  input  1  memory response strobe
  o_inst_req  output  1  memory request, registered
  o_inst_req_addr  output  32  memory request address, registered
  o_inst_data  output  32  instruction to decode, registered
  o_pc  output  32  PC of o_inst_data, registered
  o_valid  output  1  o_inst_data is a real fetched instruction
  o_level  output  $clog2(DEPTH)+1  current queue occupancy

Function
REQ-003 The block SHALL hold a fetch PC (fpc), a DEPTH-entry FIFO of {pc, inst}, and a 1-bit drop flag.
REQ-004 Request handshake: once o_inst_req is high, o_inst_req and o_inst_req_addr SHALL stay constant until a rising edge with i_inst_ack=1.
REQ-005 i_inst_ack sampled while o_inst_req=0 SHALL be ignored.
REQ-006 At most one request SHALL be outstanding.
REQ-007 A new request SHALL be registered (o_inst_req=1, o_inst_req_addr=fpc) only when no request is outstanding and level+1 <= DEPTH after any same-cycle pop.
REQ-008 The state machine SHALL have states IDLE (no request), REQ (request outstanding, keep), and DRAIN (request outstanding, drop=1).
REQ-009 REQ with ack SHALL push {o_inst_req_addr, i_inst_data}, set fpc to fpc+4 (mod 2^32), and move to IDLE or re-issue.
REQ-010 DRAIN with ack SHALL discard the data, leave fpc unchanged, and move to IDLE.
REQ-011 Output update priority per rising edge SHALL be: i_jump > i_stall > i_flush > pop > bubble.
REQ-012 On i_jump:
  - fpc<=i_jump_addr; FIFO cleared (level 0).
  - o_inst_data<=NOP_INST, o_valid<=0, o_pc<=i_jump_addr.
  - An outstanding request moves to DRAIN.
  - A same-edge ack is discarded.
  - i_jump acts even when i_stall=1.
REQ-013 On i_stall (no jump): o_inst_data, o_pc, o_valid SHALL hold; no pop; fetching continues per REQ-007.
REQ-014 On i_flush (no jump, no stall): o_inst_data<=NOP_INST, o_valid<=0, o_pc holds; FIFO not popped.
REQ-015 Pop (no jump, stall, or flush, with FIFO non-empty): head -> o_inst_data/o_pc, o_valid<=1.
REQ-016 Bubble (FIFO empty): o_inst_data<=NOP_INST, o_valid<=0, o_pc holds.
REQ-017 A simultaneous push and pop SHALL leave level unchanged; the pop SHALL return the older entry; a push into an empty FIFO SHALL NOT be popped until the next edge (1-cycle minimum ack-to-output latency).
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH and never overflow or underflow.
REQ-019 o_level SHALL reflect the registered occupancy.

Reset
REQ-020 While i_rst_n=0, outputs SHALL be: o_inst_req=0, o_inst_req_addr=0, o_inst_data=NOP_INST, o_pc=0, o_valid=0, o_level=0.
REQ-021 While i_rst_n=0, internal state SHALL be: fpc=RESET_PC, state IDLE, drop=0.
REQ-022 Reset asserted mid-request SHALL abandon the request; an ack in the cycle after release SHALL be ignored (REQ-005).
REQ-023 The first request (addr RESET_PC) SHALL be registered on the first rising edge after i_rst_n deasserts.

Verification
REQ-024 Streaming, 1-cycle ack, no stall:
  - Stimulus: DEPTH=4, RESET_PC=0, memory returns addr^32'hA5A5_0000.
  - Response: o_pc sequence 0,4,8,... with matching data; o_valid=1 once streaming.
REQ-025 Queue fill under stall:
  - Stimulus: i_stall=1 for 20 cycles.
  - Response: o_level reaches 4; o_inst_req stays 0 while full; outputs frozen.
  - On release: four consecutive pops of pc 0..12 in order.
REQ-026 Jump while a request is outstanding:
  - Stimulus: request addr 0x10 pending, i_jump=1, i_jump_addr=0x100; ack for 0x10 arrives 3 cycles later.
  - Response: 0x10 data never appears; next request addr 0x100; o_level=0 after jump.
REQ-027 Flush:
  - Stimulus: i_flush=1 for one cycle with level=2.
  - Response: o_inst_data=32'h0000_0013, o_valid=0; level still 2; next pop delivers the older entry.
REQ-028 Simultaneous jump and stall:
  - Stimulus: i_jump=1, i_stall=1, i_jump_addr=0x200.
  - Response: o_valid=0, o_pc=0x200, FIFO cleared, next request addr 0x200.
REQ-029 Reset mid-stream:
  - Stimulus: i_rst_n low with level=3 and a request outstanding.
  - Response: all outputs at reset values immediately (asynchronous); after release, first request addr=RESET_PC.
